enc_frame_ctrl: RTL and testbench

- Codeword sequencer between the message source and the `encoder` datapath.
- Counts MSG_BEATS message beats of ENC_SYM*EGF_DIM bits and forwards them to the encoder and to the output stream.
- After the last message beat, stalls the source and emits PAR_BEATS parity beats shifted out of the encoder.
- Marks codeword boundaries (first/last) for downstream framing.

---
 rtl/enc_pkg.sv | 15 +
 rtl/enc_frame_ctrl.sv | 117 +++++++++++
 tb/tb_enc_frame_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/enc_pkg.sv
// Shared encoder types: beat width and the frame controller state encoding.
package enc_pkg;

    localparam int ENC_SYM = 2;
    localparam int EGF_DIM = 8;
    localparam int BEAT_W  = ENC_SYM * EGF_DIM;

    typedef logic [BEAT_W-1:0] sym_beat_t;

    typedef enum logic {
        ST_MSG,
        ST_PAR
    } enc_ctrl_state_t;

endpackage

// File: rtl/enc_frame_ctrl.sv
// Codeword sequencer: forwards MSG_BEATS message beats, then emits PAR_BEATS parity beats.
// Optional statistics outputs (cw_count, cw_partial) are enabled by defining ENC_CTRL_STATS_EN.
module enc_frame_ctrl
    import enc_pkg::*;
#(
    parameter int MSG_BEATS = 4,
    parameter int PAR_BEATS = 2,
    parameter int CNT_W     = $clog2((MSG_BEATS > PAR_BEATS) ? MSG_BEATS : PAR_BEATS) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            src_valid,
    input  sym_beat_t       src_data,
    output logic            src_ready,
    output sym_beat_t       enc_data,
    output logic            enc_en,
    output logic            enc_first,
    output logic            enc_shift,
    input  sym_beat_t       par_data,
    output logic            dst_valid,
    output sym_beat_t       dst_data,
    output logic            dst_last,
`ifdef ENC_CTRL_STATS_EN
    output logic [15:0]     cw_count,
    output logic            cw_partial,
`endif
    input  logic            dst_ready
);

    localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(MSG_BEATS - 1);
    localparam logic [CNT_W-1:0] PAR_LAST = CNT_W'(PAR_BEATS - 1);

    enc_ctrl_state_t  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fire;

    assign enc_data = src_data;

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fire      = 1'b0;
        src_ready = 1'b0;
        dst_valid = 1'b0;
        dst_data  = src_data;
        dst_last  = 1'b0;
        enc_en    = 1'b0;
        enc_first = 1'b0;
        enc_shift = 1'b0;

        unique case (state_q)
            ST_MSG: begin
                src_ready = dst_ready;
                dst_valid = src_valid;
                dst_data  = src_data;
                fire      = src_valid && dst_ready;
                enc_en    = fire;
                enc_first = fire && (cnt_q == '0);
                if (fire) begin
                    if (cnt_q == MSG_LAST) begin
                        state_d = ST_PAR;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_PAR: begin
                dst_valid = 1'b1;
                dst_data  = par_data;
                fire      = dst_ready;
                enc_shift = fire;
                dst_last  = (cnt_q == PAR_LAST);
                if (fire) begin
                    if (cnt_q == PAR_LAST) begin
                        state_d = ST_MSG;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_MSG;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef ENC_CTRL_STATS_EN
    logic [15:0] cw_count_q;
    logic        cw_partial_q;

    // A reset flags the codeword it interrupted; a reset on a clean boundary clears the flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cw_count_q   <= '0;
            cw_partial_q <= (state_q == ST_PAR) || (cnt_q != '0);
        end else if (fire && dst_last && (cw_count_q != 16'hFFFF)) begin
            cw_count_q <= cw_count_q + 16'd1;
        end
    end

    assign cw_count   = cw_count_q;
    assign cw_partial = cw_partial_q;
`endif

endmodule

// File: tb/tb_enc_frame_ctrl.sv
// Self-checking bench for enc_frame_ctrl: directed scenarios plus randomized traffic
// checked cycle by cycle against a codeword-position reference model.
module tb_enc_frame_ctrl;
    import enc_pkg::*;

    localparam int MSG_BEATS = 4;
    localparam int PAR_BEATS = 2;
    localparam int TOT_BEATS = MSG_BEATS + PAR_BEATS;

    logic      clk = 1'b0;
    logic      rst;
    logic      src_valid;
    sym_beat_t src_data;
    logic      src_ready;
    sym_beat_t enc_data;
    logic      enc_en;
    logic      enc_first;
    logic      enc_shift;
    sym_beat_t par_data;
    logic      dst_valid;
    sym_beat_t dst_data;
    logic      dst_last;
    logic      dst_ready;
`ifdef ENC_CTRL_STATS_EN
    logic [15:0] cw_count;
    logic        cw_partial;
`endif

    enc_frame_ctrl #(.MSG_BEATS(MSG_BEATS), .PAR_BEATS(PAR_BEATS)) dut (
        .clk       (clk),
        .rst       (rst),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_ready (src_ready),
        .enc_data  (enc_data),
        .enc_en    (enc_en),
        .enc_first (enc_first),
        .enc_shift (enc_shift),
        .par_data  (par_data),
        .dst_valid (dst_valid),
        .dst_data  (dst_data),
        .dst_last  (dst_last),
`ifdef ENC_CTRL_STATS_EN
        .cw_count  (cw_count),
        .cw_partial(cw_partial),
`endif
        .dst_ready (dst_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: position of the next beat within the codeword (0..TOT_BEATS-1).
    int pos = 0;
    int cw_m = 0;
    bit part_m = 1'b0;

    // Per-scenario observations of DUT activity.
    int cyc, en_cnt, shift_cnt, srdy_low, beat_cnt, first_low;
    int first_q[$];
    int last_q[$];

    sym_beat_t beats[MSG_BEATS] = '{16'h0123, 16'h4567, 16'h89ab, 16'hcdef};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clear_obs();
        cyc = 0; en_cnt = 0; shift_cnt = 0; srdy_low = 0; beat_cnt = 0; first_low = -1;
        first_q.delete();
        last_q.delete();
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1; src_valid = 1'b0; dst_ready = 1'b1;
        @(posedge clk);
        part_m = (pos != 0);
        pos    = 0;
        cw_m   = 0;
    endtask

    task automatic cycle(input logic v, input sym_beat_t d, input logic rdy, input sym_beat_t p);
        bit   in_msg;
        logic e_fire;
        @(negedge clk);
        rst = 1'b0; src_valid = v; src_data = v ? d : 'x; dst_ready = rdy; par_data = p;
        #1;
        in_msg = (pos < MSG_BEATS);
        if (in_msg) begin
            e_fire = v && rdy;
            check("src_ready", src_ready, rdy);
            check("dst_valid", dst_valid, v);
            if (v) begin
                check("dst_data_msg", dst_data, d);
                check("enc_data", enc_data, d);
            end
            check("enc_en", enc_en, e_fire);
            check("enc_first", enc_first, e_fire && pos == 0);
            check("enc_shift", enc_shift, 1'b0);
            check("dst_last", dst_last, 1'b0);
        end else begin
            e_fire = rdy;
            check("src_ready", src_ready, 1'b0);
            check("dst_valid", dst_valid, 1'b1);
            check("dst_data_par", dst_data, p);
            check("enc_en", enc_en, 1'b0);
            check("enc_first", enc_first, 1'b0);
            check("enc_shift", enc_shift, rdy);
            check("dst_last", dst_last, (pos - MSG_BEATS) == PAR_BEATS - 1);
        end
`ifdef ENC_CTRL_STATS_EN
        check("cw_count", cw_count, cw_m);
        check("cw_partial", cw_partial, part_m);
`endif
        if (enc_first) first_q.push_back(cyc);
        if (enc_en) en_cnt++;
        if (enc_shift) shift_cnt++;
        if (!src_ready) begin
            srdy_low++;
            if (first_low < 0) first_low = cyc;
        end
        if (dst_valid && dst_ready) beat_cnt++;
        if (dst_valid && dst_ready && dst_last) last_q.push_back(cyc);
        if (e_fire) begin
            if (pos == TOT_BEATS - 1 && cw_m < 16'hFFFF) cw_m++;
            pos = (pos + 1) % TOT_BEATS;
        end
        cyc++;
    endtask

    // Drive a full-rate beat: message data from the table while in the message phase.
    task automatic full_rate(input sym_beat_t p);
        cycle(1'b1, beats[pos % MSG_BEATS], 1'b1, p);
    endtask

    initial begin
        rst = 1'b1; src_valid = 1'b0; src_data = '0; dst_ready = 1'b0; par_data = '0;
        repeat (2) @(posedge clk);
        reset_dut();

        // Reset state: idle source, downstream ready.
        clear_obs();
        cycle(1'b0, '0, 1'b1, 16'h5555);
        check("rst_src_ready", src_ready, 1'b1);
        check("rst_dst_valid", dst_valid, 1'b0);

        // Single codeword at full rate.
        reset_dut();
        clear_obs();
        for (int i = 0; i < TOT_BEATS; i++) full_rate(sym_beat_t'(16'hA000 + i));
        check("t1_en_cnt", en_cnt, 4);
        check("t1_shift_cnt", shift_cnt, 2);
        check("t1_srdy_low", srdy_low, 2);
        check("t1_first_n", first_q.size(), 1);
        check("t1_first0", (first_q.size() > 0) ? first_q[0] : -1, 0);
        check("t1_last", (last_q.size() > 0) ? last_q[0] : -1, 5);

        // Three back-to-back codewords, no bubbles.
        reset_dut();
        clear_obs();
        for (int i = 0; i < 3 * TOT_BEATS; i++) full_rate(sym_beat_t'(16'hB000 + i));
        check("t2_beats", beat_cnt, 18);
        check("t2_first_n", first_q.size(), 3);
        for (int i = 0; i < 3; i++)
            check("t2_first_cyc", (first_q.size() > i) ? first_q[i] : -1, 6 * i);
`ifdef ENC_CTRL_STATS_EN
        cycle(1'b0, '0, 1'b1, '0);
        check("t2_cw_count", cw_count, 3);
`endif

        // Downstream stall on the first parity beat.
        reset_dut();
        clear_obs();
        for (int i = 0; i < MSG_BEATS; i++) full_rate('0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'hdead, 1'b0, 16'h7e57);
        check("t3_shift_stall", shift_cnt, 0);
        cycle(1'b1, 16'hdead, 1'b1, 16'h7e57);
        cycle(1'b1, 16'hdead, 1'b1, 16'h1234);
        check("t3_shift_cnt", shift_cnt, 2);
        check("t3_last", (last_q.size() > 0) ? last_q[0] : -1, 8);

        // Source valid gaps.
        reset_dut();
        clear_obs();
        cycle(1'b1, beats[0], 1'b1, '0);
        cycle(1'b0, '0, 1'b1, '0);
        cycle(1'b1, beats[1], 1'b1, '0);
        cycle(1'b0, '0, 1'b1, '0);
        cycle(1'b0, '0, 1'b1, '0);
        cycle(1'b1, beats[2], 1'b1, '0);
        cycle(1'b1, beats[3], 1'b1, '0);
        cycle(1'b1, beats[0], 1'b1, 16'hC001);
        cycle(1'b1, beats[0], 1'b1, 16'hC002);
        check("t4_en_cnt", en_cnt, 4);
        check("t4_par_entry", first_low, 7);
        check("t4_last", (last_q.size() > 0) ? last_q[0] : -1, 8);

        // Reset in the middle of a codeword.
        reset_dut();
        clear_obs();
        full_rate('0);
        full_rate('0);
        reset_dut();
        clear_obs();
        for (int i = 0; i < TOT_BEATS; i++) full_rate(sym_beat_t'(16'hD000 + i));
        check("t5_first_n", first_q.size(), 1);
        check("t5_first0", (first_q.size() > 0) ? first_q[0] : -1, 0);
        check("t5_last", (last_q.size() > 0) ? last_q[0] : -1, 5);
`ifdef ENC_CTRL_STATS_EN
        check("t5_partial", cw_partial, 1'b1);
`endif

        // Randomized traffic with occasional resets.
        clear_obs();
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                reset_dut();
            end else begin
                cycle(($urandom_range(0, 3) != 0), sym_beat_t'($urandom),
                      ($urandom_range(0, 3) != 0), sym_beat_t'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
